rv32i_mem_arbiter: RTL and testbench

RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

---
 rtl/rv32i_mem_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// RV32I memory arbiter: fetch and load/store ports sharing one 16-bit bus.
// Data wins ties; word accesses and fetches are split into two halfword beats.
module rv32i_mem_arbiter #(
    parameter int XLEN     = 32,
    parameter int BUS_BITS = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                if_req_i,
    input  logic [XLEN-1:0]     if_addr_i,
    output logic                if_ack_o,
    output logic [XLEN-1:0]     if_data_o,
    output logic                if_fault_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [2:0]          d_funct3_i,
    input  logic [XLEN-1:0]     d_addr_i,
    input  logic [XLEN-1:0]     d_wdata_i,
    output logic                d_ack_o,
    output logic [XLEN-1:0]     d_rdata_o,
    output logic                d_fault_o,
    output logic [XLEN-1:0]     bus_addr_o,
    output logic                bus_read_o,
    output logic                bus_write_o,
    output logic [BUS_BITS-1:0] bus_wdata_o,
    output logic [1:0]          bus_mask_o,
    input  logic [BUS_BITS-1:0] bus_rdata_i,
    input  logic                bus_ready_i,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1,
        S_ACK
    } state_t;

    state_t r_state;
    state_t w_next;

    logic            r_is_d;
    logic [XLEN-1:0] r_addr;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_wdata;
    logic            r_fault;
    logic [15:0]     r_lo;
    logic [XLEN-1:0] r_if_data;
    logic [XLEN-1:0] r_d_rdata;

    logic            w_any_req;
    logic            w_d_misalign;
    logic            w_d_illegal;
    logic            w_fault;
    logic            w_two;
    logic            w_beat;
    logic            w_last_done;
    logic [15:0]     w_half_rd;
    logic [7:0]      w_byte_rd;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_result;
    logic [15:0]     w_half_wr;

    // ---------------- request decode ----------------
    assign w_any_req = d_req_i | if_req_i;

    always_comb begin
        w_d_misalign = 1'b0;
        unique case (d_funct3_i[1:0])
            2'b01:   w_d_misalign = d_addr_i[0];
            2'b10:   w_d_misalign = |d_addr_i[1:0];
            default: w_d_misalign = 1'b0;
        endcase
    end

    // Stores only know SB/SH/SW; loads additionally allow LBU/LHU.
    always_comb begin
        if (d_we_i) begin
            w_d_illegal = d_funct3_i[2] | (&d_funct3_i[1:0]);
        end else begin
            w_d_illegal = (&d_funct3_i[1:0])
                        | (d_funct3_i[2] & d_funct3_i[1]);
        end
    end

    assign w_fault = d_req_i ? (w_d_illegal | w_d_misalign)
                             : (|if_addr_i[1:0]);

    // ---------------- FSM ----------------
    assign w_two  = ~r_is_d | (r_funct3[1:0] == 2'b10);
    assign w_beat = (r_state == S_BEAT0) | (r_state == S_BEAT1);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = w_fault ? S_ACK : S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (bus_ready_i) begin
                    w_next = w_two ? S_BEAT1 : S_ACK;
                end
            end
            S_BEAT1: begin
                if (bus_ready_i) begin
                    w_next = S_ACK;
                end
            end
            S_ACK: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_last_done = bus_ready_i
                       & ((r_state == S_BEAT1)
                       | ((r_state == S_BEAT0) & ~w_two));

    // ---------------- read path ----------------
    // Even byte arrives on [15:8]; swap into little-endian halfword order.
    assign w_half_rd = {bus_rdata_i[7:0], bus_rdata_i[15:8]};
    assign w_byte_rd = r_addr[0] ? bus_rdata_i[7:0] : bus_rdata_i[15:8];

    always_comb begin
        w_load = '0;
        unique case (r_funct3)
            3'b000:  w_load = {{(XLEN-8){w_byte_rd[7]}}, w_byte_rd};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte_rd};
            3'b001:  w_load = {{(XLEN-16){w_half_rd[15]}}, w_half_rd};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half_rd};
            default: w_load = '0;
        endcase
    end

    assign w_result = w_two ? {w_half_rd, r_lo} : w_load;

    // ---------------- capture and result registers ----------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_is_d    <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_funct3  <= '0;
            r_wdata   <= '0;
            r_fault   <= 1'b0;
            r_lo      <= '0;
            r_if_data <= '0;
            r_d_rdata <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_any_req) begin
                r_is_d   <= d_req_i;
                r_addr   <= d_req_i ? d_addr_i : if_addr_i;
                r_we     <= d_req_i & d_we_i;
                r_funct3 <= d_req_i ? d_funct3_i : 3'b010;
                r_wdata  <= d_wdata_i;
                r_fault  <= w_fault;
                if (w_fault) begin
                    if (d_req_i) begin
                        r_d_rdata <= '0;
                    end else begin
                        r_if_data <= '0;
                    end
                end
            end
            if ((r_state == S_BEAT0) && bus_ready_i) begin
                r_lo <= w_half_rd;
            end
            if (w_last_done) begin
                if (r_is_d) begin
                    r_d_rdata <= r_we ? '0 : w_result;
                end else begin
                    r_if_data <= w_result;
                end
            end
        end
    end

    // ---------------- bus drive ----------------
    assign w_half_wr = (r_state == S_BEAT1) ? r_wdata[31:16]
                                            : r_wdata[15:0];

    always_comb begin
        bus_addr_o  = '0;
        bus_read_o  = 1'b0;
        bus_write_o = 1'b0;
        bus_wdata_o = '0;
        bus_mask_o  = 2'b00;
        if (w_beat) begin
            bus_read_o  = ~r_we;
            bus_write_o = r_we;
            bus_mask_o  = 2'b11;
            if (r_state == S_BEAT1) begin
                bus_addr_o = {r_addr[XLEN-1:2], 2'b10};
            end else if (w_two) begin
                bus_addr_o = {r_addr[XLEN-1:2], 2'b00};
            end else begin
                bus_addr_o = {r_addr[XLEN-1:1], 1'b0};
            end
            if (r_we) begin
                if (r_funct3[1:0] == 2'b00) begin
                    bus_wdata_o = r_addr[0] ? {8'h00, r_wdata[7:0]}
                                            : {r_wdata[7:0], 8'h00};
                    bus_mask_o  = r_addr[0] ? 2'b01 : 2'b10;
                end else begin
                    bus_wdata_o = {w_half_wr[7:0], w_half_wr[15:8]};
                end
            end
        end
    end

    // ---------------- requester outputs ----------------
    assign if_ack_o   = (r_state == S_ACK) & ~r_is_d;
    assign d_ack_o    = (r_state == S_ACK) & r_is_d;
    assign if_fault_o = if_ack_o & r_fault;
    assign d_fault_o  = d_ack_o & r_fault;
    assign if_data_o  = r_if_data;
    assign d_rdata_o  = r_d_rdata;
    assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: vector table for data accesses,
// hand-written sequences for fetch, priority, wait states and reset.
module tb_rv32i_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_data_o;
    logic        if_fault_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [2:0]  d_funct3_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_ack_o;
    logic [31:0] d_rdata_o;
    logic        d_fault_o;
    logic [31:0] bus_addr_o;
    logic        bus_read_o;
    logic        bus_write_o;
    logic [15:0] bus_wdata_o;
    logic [1:0]  bus_mask_o;
    logic [15:0] bus_rdata_i;
    logic        bus_ready_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    rv32i_mem_arbiter #(.XLEN(32), .BUS_BITS(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
        .if_data_o(if_data_o), .if_fault_o(if_fault_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_funct3_i(d_funct3_i),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o),
        .d_rdata_o(d_rdata_o), .d_fault_o(d_fault_o),
        .bus_addr_o(bus_addr_o), .bus_read_o(bus_read_o),
        .bus_write_o(bus_write_o), .bus_wdata_o(bus_wdata_o),
        .bus_mask_o(bus_mask_o), .bus_rdata_i(bus_rdata_i),
        .bus_ready_i(bus_ready_i), .busy_o(busy_o)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] rd0;
        logic [15:0] rd1;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_beats;
        logic [31:0] exp_a0;
        logic [31:0] exp_an;
        logic [15:0] exp_w0;
        logic [15:0] exp_wn;
        logic [1:0]  exp_mask;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int beats;
        bit got;
        bit wr;
        logic [31:0] a0, an;
        logic [15:0] w0, wn;
        logic [1:0]  m0;
        lat = 0; beats = 0; got = 0; wr = 0;
        a0 = '0; an = '0; w0 = '0; wn = '0; m0 = '0;
        @(negedge clk_i);
        d_req_i = 1'b1;
        d_we_i = v.we;
        d_funct3_i = v.f3;
        d_addr_i = v.addr;
        d_wdata_i = v.wdata;
        bus_ready_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            if (bus_read_o || bus_write_o) begin
                if (beats == 0) begin
                    a0 = bus_addr_o; w0 = bus_wdata_o; m0 = bus_mask_o;
                end
                an = bus_addr_o; wn = bus_wdata_o; wr = bus_write_o;
                bus_rdata_i = (beats == 0) ? v.rd0 : v.rd1;
                beats++;
            end
            if (d_ack_o) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        chk({tag, " ack_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " beats"}, beats, v.exp_beats);
        chk({tag, " fault"}, 32'(d_fault_o), 32'(v.exp_fault));
        if (!v.we || v.exp_fault) chk({tag, " rdata"}, d_rdata_o, v.exp_rdata);
        if (beats > 0) begin
            chk({tag, " addr0"}, a0, v.exp_a0);
            chk({tag, " addrN"}, an, v.exp_an);
            chk({tag, " wdata0"}, 32'(w0), 32'(v.exp_w0));
            chk({tag, " wdataN"}, 32'(wn), 32'(v.exp_wn));
            chk({tag, " mask"}, 32'(m0), 32'(v.exp_mask));
            chk({tag, " is_write"}, 32'(wr), 32'(v.we));
        end
        d_req_i = 1'b0;
        @(negedge clk_i);
        chk({tag, " ack_pulse"}, 32'(d_ack_o), 32'd0);
        chk({tag, " idle"}, 32'(busy_o), 32'd0);
        if (!v.we) chk({tag, " rdata_held"}, d_rdata_o, v.exp_rdata);
    endtask

    task automatic run_fetch(input logic [31:0] addr, input logic [15:0] rd0,
                             input logic [15:0] rd1, input logic [31:0] exp_d,
                             input logic exp_f, input int exp_lat,
                             input string tag);
        int lat;
        int beats;
        bit got;
        bit wr;
        logic [31:0] a0, an;
        lat = 0; beats = 0; got = 0; wr = 0; a0 = '0; an = '0;
        @(negedge clk_i);
        if_req_i = 1'b1;
        if_addr_i = addr;
        bus_ready_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            if (bus_read_o || bus_write_o) begin
                if (beats == 0) a0 = bus_addr_o;
                an = bus_addr_o;
                wr = wr | bus_write_o;
                bus_rdata_i = (beats == 0) ? rd0 : rd1;
                beats++;
            end
            if (if_ack_o) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        chk({tag, " ack_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " data"}, if_data_o, exp_d);
        chk({tag, " fault"}, 32'(if_fault_o), 32'(exp_f));
        chk({tag, " beats"}, beats, exp_f ? 0 : 2);
        chk({tag, " no_write"}, 32'(wr), 32'd0);
        if (beats > 0) begin
            chk({tag, " addr0"}, a0, {addr[31:2], 2'b00});
            chk({tag, " addr1"}, an, {addr[31:2], 2'b10});
        end
        if_req_i = 1'b0;
        @(negedge clk_i);
        chk({tag, " ack_pulse"}, 32'(if_ack_o), 32'd0);
    endtask

    initial begin
        int d_lat, f_lat, nb, acks;
        logic [31:0] alog[8];
        logic [15:0] rtab[4];

        //            we  f3      addr          wdata         rd0       rd1       rdata         flt lat bt a0            aN            w0        wN        mask
        vecs[0]  = '{1'b0, 3'b000, 32'h203, 32'h0,        16'h1280, 16'h0,    32'hFFFFFF80, 1'b0, 2, 1, 32'h202, 32'h202, 16'h0,    16'h0,    2'b11};
        vecs[1]  = '{1'b0, 3'b100, 32'h203, 32'h0,        16'h1280, 16'h0,    32'h00000080, 1'b0, 2, 1, 32'h202, 32'h202, 16'h0,    16'h0,    2'b11};
        vecs[2]  = '{1'b0, 3'b000, 32'h202, 32'h0,        16'h7F12, 16'h0,    32'h0000007F, 1'b0, 2, 1, 32'h202, 32'h202, 16'h0,    16'h0,    2'b11};
        vecs[3]  = '{1'b0, 3'b001, 32'h202, 32'h0,        16'h3485, 16'h0,    32'hFFFF8534, 1'b0, 2, 1, 32'h202, 32'h202, 16'h0,    16'h0,    2'b11};
        vecs[4]  = '{1'b0, 3'b101, 32'h202, 32'h0,        16'h3485, 16'h0,    32'h00008534, 1'b0, 2, 1, 32'h202, 32'h202, 16'h0,    16'h0,    2'b11};
        vecs[5]  = '{1'b0, 3'b010, 32'h100, 32'h0,        16'h1234, 16'h5678, 32'h78563412, 1'b0, 3, 2, 32'h100, 32'h102, 16'h0,    16'h0,    2'b11};
        vecs[6]  = '{1'b0, 3'b010, 32'h102, 32'h0,        16'h0,    16'h0,    32'h0,        1'b1, 1, 0, 32'h0,   32'h0,   16'h0,    16'h0,    2'b00};
        vecs[7]  = '{1'b0, 3'b001, 32'h201, 32'h0,        16'h0,    16'h0,    32'h0,        1'b1, 1, 0, 32'h0,   32'h0,   16'h0,    16'h0,    2'b00};
        vecs[8]  = '{1'b0, 3'b011, 32'h100, 32'h0,        16'h0,    16'h0,    32'h0,        1'b1, 1, 0, 32'h0,   32'h0,   16'h0,    16'h0,    2'b00};
        vecs[9]  = '{1'b0, 3'b110, 32'h100, 32'h0,        16'h0,    16'h0,    32'h0,        1'b1, 1, 0, 32'h0,   32'h0,   16'h0,    16'h0,    2'b00};
        vecs[10] = '{1'b1, 3'b000, 32'h201, 32'hDEADBEEF, 16'h0,    16'h0,    32'h0,        1'b0, 2, 1, 32'h200, 32'h200, 16'h00EF, 16'h00EF, 2'b01};
        vecs[11] = '{1'b1, 3'b000, 32'h200, 32'hDEADBEEF, 16'h0,    16'h0,    32'h0,        1'b0, 2, 1, 32'h200, 32'h200, 16'hEF00, 16'hEF00, 2'b10};
        vecs[12] = '{1'b1, 3'b001, 32'h206, 32'h0000CAFE, 16'h0,    16'h0,    32'h0,        1'b0, 2, 1, 32'h206, 32'h206, 16'hFECA, 16'hFECA, 2'b11};
        vecs[13] = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 16'h0,    16'h0,    32'h0,        1'b0, 3, 2, 32'h100, 32'h102, 16'hEFBE, 16'hADDE, 2'b11};
        vecs[14] = '{1'b1, 3'b010, 32'h102, 32'h0,        16'h0,    16'h0,    32'h0,        1'b1, 1, 0, 32'h0,   32'h0,   16'h0,    16'h0,    2'b00};
        vecs[15] = '{1'b1, 3'b011, 32'h100, 32'h0,        16'h0,    16'h0,    32'h0,        1'b1, 1, 0, 32'h0,   32'h0,   16'h0,    16'h0,    2'b00};
        vecs[16] = '{1'b0, 3'b010, 32'h104, 32'h0,        16'hFFFF, 16'h0080, 32'h8000FFFF, 1'b0, 3, 2, 32'h104, 32'h106, 16'h0,    16'h0,    2'b11};

        reset_i = 1'b0;
        if_req_i = 1'b1;
        if_addr_i = 32'h100;
        d_req_i = 1'b1;
        d_we_i = 1'b1;
        d_funct3_i = 3'b010;
        d_addr_i = 32'h100;
        d_wdata_i = 32'hFFFFFFFF;
        bus_rdata_i = 16'hFFFF;
        bus_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst if_ack", 32'(if_ack_o), 32'd0);
        chk("rst d_ack", 32'(d_ack_o), 32'd0);
        chk("rst if_fault", 32'(if_fault_o), 32'd0);
        chk("rst d_fault", 32'(d_fault_o), 32'd0);
        chk("rst read", 32'(bus_read_o), 32'd0);
        chk("rst write", 32'(bus_write_o), 32'd0);
        chk("rst mask", 32'(bus_mask_o), 32'd0);
        chk("rst addr", bus_addr_o, 32'd0);
        chk("rst wdata", 32'(bus_wdata_o), 32'd0);
        chk("rst if_data", if_data_o, 32'd0);
        chk("rst d_rdata", d_rdata_o, 32'd0);
        if_req_i = 1'b0;
        d_req_i = 1'b0;
        reset_i = 1'b1;

        run_fetch(32'h100, 16'h1234, 16'h5678, 32'h78563412, 1'b0, 3, "fetch");
        run_fetch(32'h102, 16'h0, 16'h0, 32'h0, 1'b1, 1, "fetch_mis");

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Wait states: fault first, then SW with ready low two cycles per beat.
        run_vec(vecs[6], "lw_fault");
        @(negedge clk_i);
        d_req_i = 1'b1;
        d_we_i = 1'b1;
        d_funct3_i = 3'b010;
        d_addr_i = 32'h100;
        d_wdata_i = 32'h12345678;
        bus_ready_i = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_i);
            if (c <= 6) begin
                chk($sformatf("ws write c%0d", c), 32'(bus_write_o), 32'd1);
                chk($sformatf("ws addr c%0d", c), bus_addr_o,
                    (c <= 3) ? 32'h100 : 32'h102);
                chk($sformatf("ws wdata c%0d", c), 32'(bus_wdata_o),
                    (c <= 3) ? 32'h7856 : 32'h3412);
                chk($sformatf("ws noack c%0d", c), 32'(d_ack_o), 32'd0);
                bus_ready_i = (c % 3 == 0);
            end else begin
                chk("ws ack T+7", 32'(d_ack_o), 32'd1);
            end
        end
        d_req_i = 1'b0;
        bus_ready_i = 1'b1;
        @(negedge clk_i);

        // Simultaneous requests: data first, no interleaving.
        rtab[0] = 16'h0102;
        rtab[1] = 16'h0304;
        rtab[2] = 16'h0506;
        rtab[3] = 16'h0708;
        d_lat = 0;
        f_lat = 0;
        nb = 0;
        @(negedge clk_i);
        d_req_i = 1'b1;
        d_we_i = 1'b0;
        d_funct3_i = 3'b010;
        d_addr_i = 32'h200;
        if_req_i = 1'b1;
        if_addr_i = 32'h300;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            if (bus_read_o || bus_write_o) begin
                if (nb < 8) alog[nb] = bus_addr_o;
                if (nb < 4) bus_rdata_i = rtab[nb];
                nb++;
            end
            if (d_ack_o) begin
                d_lat = c;
                chk("prio d_rdata", d_rdata_o, 32'h04030201);
                chk("prio if_ack_early", 32'(if_ack_o), 32'd0);
                d_req_i = 1'b0;
            end
            if (if_ack_o) begin
                f_lat = c;
                chk("prio if_data", if_data_o, 32'h08070605);
                if_req_i = 1'b0;
                break;
            end
        end
        chk("prio d_lat", d_lat, 3);
        chk("prio f_lat", f_lat, 7);
        chk("prio beats", nb, 4);
        if (nb >= 4) begin
            chk("prio beat0", alog[0], 32'h200);
            chk("prio beat1", alog[1], 32'h202);
            chk("prio beat2", alog[2], 32'h300);
            chk("prio beat3", alog[3], 32'h302);
        end
        chk("prio d_rdata_held", d_rdata_o, 32'h04030201);
        if_req_i = 1'b0;
        d_req_i = 1'b0;
        @(negedge clk_i);

        // Asynchronous reset in BEAT1 of a fetch.
        @(negedge clk_i);
        if_req_i = 1'b1;
        if_addr_i = 32'h400;
        bus_ready_i = 1'b1;
        @(negedge clk_i);
        chk("rb beat0 read", 32'(bus_read_o), 32'd1);
        @(negedge clk_i);
        chk("rb beat1 addr", bus_addr_o, 32'h402);
        #2;
        reset_i = 1'b0;
        #1;
        chk("rb read async", 32'(bus_read_o), 32'd0);
        chk("rb busy async", 32'(busy_o), 32'd0);
        chk("rb addr async", bus_addr_o, 32'd0);
        if_req_i = 1'b0;
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            acks += int'(if_ack_o) + int'(d_ack_o);
        end
        chk("rb no_ack", acks, 0);
        reset_i = 1'b1;
        run_vec(vecs[0], "after_rst");
        run_fetch(32'h100, 16'h1234, 16'h5678, 32'h78563412, 1'b0, 3, "fetch2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
